port_comparator: RTL and testbench
==================================

// Module: port_comparator
// PURPOSE
//  Streaming 16-bit port-number matcher in the Ethernet sniffer datapath. Watches a 32-bit word
//  stream for flagged_port at any byte alignment, including across a word boundary. Passes the
//  stream through a fixed 3-cycle delay so match lines up with the word that starts the hit window.
//  match is sticky until clear, so downstream logic can tag the whole frame.
// PARAMETERS
//  DATA_W    32  stream word width; must be a multiple of 8.
//  PORT_W    16  port field width; must be a multiple of 8 and no wider than DATA_W.
//  PIPE_LEN  3   data_in -> data_out latency in cycles; fixed at 3 for this block.
// PORTS
//  clk           in   1       rising-edge clock; the only clock.
//  n_rst         in   1       reset, asynchronous, active-low.
//  clear         in   1       synchronous clear: drops match and flushes the pipeline.
//  flagged_port  in   16      port value to detect; treated as static during a frame.
//  data_in       in   32      stream word; one word accepted every cycle, no valid or stall.
//  data_out      out  32      data_in delayed by exactly 3 cycles (registered).
//  match         out  1       registered, sticky hit flag.
// BEHAVIOUR
//  - Pipeline: r1<=data_in, r2<=r1, r3<=r2; data_out=r3.
//  - Reset (n_rst=0, async): r1/r2/r3=0, data_out=0, match=0.
//  - Stream byte order is LSB-first: byte0 of a word arrives before byte3.
//  - Window W[63:0]={r1,r2}; r1 holds the newer word.
//  - hit = OR over k=0..6 of (W[8k+15:8k]==flagged_port), i.e. 7 byte offsets.
//  - Offsets k=0..2 lie inside r2; k=3 straddles the r2/r1 boundary; k=4..6 lie inside r1.
//  - Each clock edge: if clear, match<=0; else if hit, match<=1; else match holds.
//  - Timing: match rises in the same cycle data_out shows the older word of the hit window (r2 -> r3).
//  - Cycle example: word A enters at edge1; word B enters at edge2; after edge3 data_out=A and match=1.
//  - clear: zeroes r1/r2/r3 and match on the next edge. clear has priority over a hit on the same
//    edge. While clear=1, data_out reads 0 on the following cycle.
//  - Zero-valued stream words are ordinary data. flagged_port=0x0000 therefore matches any zero bytes.
//  - Reset asserted mid-stream: all state drops to 0 immediately, with no partial-window memory.
//  - A hit that is reached again while match=1 has no further effect.
// CONFIGURATION
//  Macro PORT_COMPARATOR_OFFSET_EN:
//  - Defined: adds output match_offset[2:0]. It holds the k of the first (lowest-k) hit that set match.
//    It is reset and cleared to 0 with match, and frozen while match=1.
//  - Undefined: the port is absent, and the block behaves exactly as described above.
// STRUCTURE
//  - Package port_comparator_pkg:
//    - DATA_W, PORT_W, PIPE_LEN, NUM_OFFSETS=7.
//    - typedef word_t (logic[31:0]), port_t (logic[15:0]), offset_t (logic[2:0]).
//  - Sub-module byte_window_match (combinational):
//    - Inputs: window[63:0] and port_t.
//    - Outputs: hit, plus offset_t of the lowest matching k.
//  - The top level holds the pipeline registers, the sticky match register and the macro-gated offset register.
// TESTING
//  - Reset: n_rst=0 -> data_out=0, match=0 asynchronously. Release and pulse clear -> both still 0.
//  - Aligned hit:
//    - Stimulus: flagged_port=0xABCD; data_in=0x00ABCD00, then 0x00000000.
//    - match=0 one cycle after the word.
//    - After 3 edges: data_out=0x00ABCD00 and match=1; next cycle data_out=0.
//  - Hit fully in the second word: 0x00000000 then 0x0000ABCD.
//    - match=0 for the first two cycles.
//    - Then data_out=0x00000000 with match=1, followed by 0x0000ABCD, then 0.
//  - Straddling hit: 0xCD000000 then 0x000000AB.
//    - match=1 with data_out=0xCD000000, then 0x000000AB.
//  - High-half hit: 0xABCD0000 then 0x00000000 -> match=1 with data_out=0xABCD0000, then 0.
//  - Clear: a 1-cycle clear after each hit case -> match=0 on the next cycle. clear and hit on the
//    same edge -> match=0.

Source files
------------

// File: rtl/port_comparator_pkg.sv
// port_comparator_pkg: shared widths, sizes and types for the port comparator.
// Build option: PORT_COMPARATOR_OFFSET_EN adds the match_offset output.
package port_comparator_pkg;
   localparam int DATA_W      = 32;
   localparam int PORT_W      = 16;
   localparam int PIPE_LEN    = 3;
   localparam int NUM_OFFSETS = (2 * DATA_W - PORT_W) / 8 + 1;
   typedef logic [DATA_W-1:0] word_t;
   typedef logic [PORT_W-1:0] port_t;
   typedef logic [2:0]        offset_t;
endpackage

// File: rtl/port_comparator_if.sv
// port_comparator_if: stream bus of the port comparator.
// Ports: clear, flagged_port, data_in (master->slave); data_out, match and,
// with PORT_COMPARATOR_OFFSET_EN, match_offset (slave->master).
interface port_comparator_if;
   import port_comparator_pkg::*;
   logic    clear;
   port_t   flagged_port;
   word_t   data_in;
   word_t   data_out;
   logic    match;
`ifdef PORT_COMPARATOR_OFFSET_EN
   offset_t match_offset;
   modport master (output clear, flagged_port, data_in, input data_out, match, match_offset);
   modport slave  (input clear, flagged_port, data_in, output data_out, match, match_offset);
`else
   modport master (output clear, flagged_port, data_in, input data_out, match);
   modport slave  (input clear, flagged_port, data_in, output data_out, match);
`endif
endinterface

// File: rtl/port_comparator_match.sv
// byte_window_match: combinational search of a two-word window for a port value.
// Ports: window (in, {newer, older} word), port (in), hit (out), offset (out, lowest matching byte offset).
module byte_window_match
   import port_comparator_pkg::*;
(
   input  logic [2*DATA_W-1:0] window,
   input  port_t               port,
   output logic                hit,
   output offset_t             offset
);
   logic [NUM_OFFSETS-1:0] hits;
   for (genvar k = 0; k < NUM_OFFSETS; k++) begin : g_off
      assign hits[k] = window[8*k +: PORT_W] == port;
   end
   // Descending scan so the lowest matching offset is the one left standing.
   always_comb begin
      hit    = |hits;
      offset = '0;
      for (int i = NUM_OFFSETS - 1; i >= 0; i--)
         offset = hits[i] ? offset_t'(i) : offset;
   end
endmodule

// File: rtl/port_comparator.sv
// port_comparator: 3-cycle stream delay with a sticky flag for a 16-bit port value at any byte offset.
// Ports: clk, n_rst (async active-low), bus (slave modport of port_comparator_if).
// Build option: PORT_COMPARATOR_OFFSET_EN records the offset of the hit that set match.
module port_comparator
   import port_comparator_pkg::*;
(
   input logic               clk,
   input logic               n_rst,
   port_comparator_if.slave  bus
);
   word_t   r1, r2, r3;
   logic    match_q;
   logic    hit;
   offset_t hit_offset;
   // r1 is the newer word, so it forms the upper half of the window.
   byte_window_match u_match (
      .window ({r1, r2}),
      .port   (bus.flagged_port),
      .hit    (hit),
      .offset (hit_offset)
   );
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r1      <= '0;
         r2      <= '0;
         r3      <= '0;
         match_q <= 1'b0;
      end else if (bus.clear) begin
         r1      <= '0;
         r2      <= '0;
         r3      <= '0;
         match_q <= 1'b0;
      end else begin
         r1      <= bus.data_in;
         r2      <= r1;
         r3      <= r2;
         match_q <= match_q | hit;
      end
   end
   assign bus.data_out = r3;
   assign bus.match    = match_q;
`ifdef PORT_COMPARATOR_OFFSET_EN
   offset_t offset_q;
   // Latch only on the rising hit; later hits leave the recorded offset alone.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         offset_q <= '0;
      else if (bus.clear)
         offset_q <= '0;
      else if (hit && !match_q)
         offset_q <= hit_offset;
   end
   assign bus.match_offset = offset_q;
`else
   logic unused_offset;
   assign unused_offset = ^hit_offset;
`endif
endmodule

// File: tb/tb_port_comparator.sv
// tb_port_comparator: directed and random checks of port_comparator against a byte-stream model.
module tb_port_comparator;
   import port_comparator_pkg::*;
   logic clk   = 1'b0;
   logic n_rst = 1'b1;
   always #5 clk = ~clk;
   port_comparator_if bus ();
   port_comparator dut (.clk(clk), .n_rst(n_rst), .bus(bus));
   int compared   = 0;
   int mismatched = 0;
   word_t   m_pipe [3];
   logic    m_match;
   offset_t m_off;
   // The two words form an 8-byte LSB-first stream; the port appears as its low byte then its high byte.
   function automatic logic find(input word_t older, input word_t newer, input port_t p, output offset_t k);
      logic [7:0] b [8];
      find = 1'b0;
      k    = '0;
      for (int i = 0; i < 4; i++) begin
         b[i]   = older[8*i +: 8];
         b[i+4] = newer[8*i +: 8];
      end
      for (int i = 6; i >= 0; i--)
         if (b[i] == p[7:0] && b[i+1] == p[15:8]) begin
            find = 1'b1;
            k    = offset_t'(i);
         end
   endfunction
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_pipe[i] = '0;
      m_match = 1'b0;
      m_off   = '0;
   endtask
   task automatic step(input word_t din, input logic clr);
      offset_t k;
      logic    h;
      bus.data_in = din;
      bus.clear   = clr;
      h = find(m_pipe[1], m_pipe[0], bus.flagged_port, k);
      @(posedge clk);
      if (clr) model_reset();
      else begin
         if (h && !m_match) m_off = k;
         m_match   = m_match | h;
         m_pipe[2] = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = din;
      end
      #1;
      chk("data_out", bus.data_out, m_pipe[2]);
      chk("match", 32'(bus.match), 32'(m_match));
`ifdef PORT_COMPARATOR_OFFSET_EN
      chk("match_offset", 32'(bus.match_offset), 32'(m_off));
`endif
   endtask
   initial begin
      port_t p;
      word_t w;
      int    j;
      bus.flagged_port = 16'hABCD;
      bus.data_in      = '0;
      bus.clear        = 1'b0;
      model_reset();
      #2 n_rst = 1'b0;
      #1;
      chk("reset data_out", bus.data_out, 32'h0);
      chk("reset match", 32'(bus.match), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) n_rst = 1'b1;
      step(32'h0, 1'b1);
      chk("clear after reset match", 32'(bus.match), 32'h0);
      // Aligned hit
      step(32'h00ABCD00, 1'b0);
      chk("aligned early match", 32'(bus.match), 32'h0);
      step(32'h0, 1'b0);
      step(32'h0, 1'b0);
      chk("aligned data_out", bus.data_out, 32'h00ABCD00);
      chk("aligned match", 32'(bus.match), 32'h1);
      step(32'h0, 1'b0);
      chk("aligned tail", bus.data_out, 32'h0);
      step(32'h0, 1'b1);
      chk("aligned clear", 32'(bus.match), 32'h0);
      // Hit fully in the newer word
      step(32'h0, 1'b0);
      step(32'h0000ABCD, 1'b0);
      chk("second word early match", 32'(bus.match), 32'h0);
      step(32'h0, 1'b0);
      chk("second word match", 32'(bus.match), 32'h1);
      step(32'h0, 1'b0);
      chk("second word data_out", bus.data_out, 32'h0000ABCD);
      step(32'h0, 1'b0);
      step(32'h0, 1'b1);
      // Straddling hit
      step(32'hCD000000, 1'b0);
      step(32'h000000AB, 1'b0);
      step(32'h0, 1'b0);
      chk("straddle data_out", bus.data_out, 32'hCD000000);
      chk("straddle match", 32'(bus.match), 32'h1);
      step(32'h0, 1'b0);
      step(32'h0, 1'b1);
      // High-half hit
      step(32'hABCD0000, 1'b0);
      step(32'h0, 1'b0);
      step(32'h0, 1'b0);
      chk("high data_out", bus.data_out, 32'hABCD0000);
      chk("high match", 32'(bus.match), 32'h1);
      step(32'h0, 1'b0);
      step(32'h0, 1'b1);
      // Clear on the same edge the straddling hit becomes visible
      step(32'hCD000000, 1'b0);
      step(32'h000000AB, 1'b0);
      step(32'h0, 1'b1);
      chk("clear beats hit", 32'(bus.match), 32'h0);
      step(32'h0, 1'b0);
      // Zero port matches zero bytes
      bus.flagged_port = 16'h0000;
      step(32'h0, 1'b1);
      step(32'h12340000, 1'b0);
      step(32'h0, 1'b0);
      chk("zero port match", 32'(bus.match), 32'h1);
      // Asynchronous reset mid-stream
      step(32'hDEADBEEF, 1'b0);
      #2 n_rst = 1'b0;
      #1;
      chk("async reset data_out", bus.data_out, 32'h0);
      chk("async reset match", 32'(bus.match), 32'h0);
      model_reset();
      @(negedge clk) n_rst = 1'b1;
      // Random frames, each opened with a clear so the port stays static within it
      for (int f = 0; f < 12; f++) begin
         p = port_t'($urandom);
         bus.flagged_port = p;
         step(word_t'($urandom), 1'b1);
         for (int i = 0; i < 30; i++) begin
            w = $urandom;
            if ($urandom_range(0, 5) == 0) begin
               j = $urandom_range(0, 2);
               w[8*j +: 16] = p;
            end
            step(w, $urandom_range(0, 24) == 0);
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
